bsg_fifo_saf_commit_ctrl: RTL and testbench

- Packet-framing controller that sits in front of a store-and-forward 1r1w FIFO with commit/drop rewind.
- Accepts framed beats from an upstream producer and forwards them into the FIFO write port.
- Decides per packet whether to commit or drop, and issues exactly one commit/drop pulse per packet.
- Guarantees that only complete, error-free packets that fit within the length limit become visible on the FIFO read side. Also keeps saturating commit/drop statistics.

---
 rtl/bsg_fifo_saf_commit_pkg.sv | 6 +
 rtl/bsg_fifo_saf_sat_counter.sv | 13 +
 rtl/bsg_fifo_saf_commit_ctrl.sv | 83 ++++++++
 tb/tb_bsg_fifo_saf_commit_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bsg_fifo_saf_commit_pkg.sv
// bsg_fifo_saf_commit_pkg: shared state encoding and disposition constants for the SAF commit controller
package bsg_fifo_saf_commit_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_COMMIT, S_ABORT, S_DISCARD} state_e;
  localparam logic DISP_COMMIT = 1'b0;
  localparam logic DISP_DROP = 1'b1;
endpackage

// File: rtl/bsg_fifo_saf_sat_counter.sv
// bsg_fifo_saf_sat_counter: up-counter with enable that sticks at all-ones
module bsg_fifo_saf_sat_counter #(
  parameter int width_p = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
  output logic [width_p-1:0] o_count
);
  always_ff @(posedge i_clk)
    if (i_reset) o_count <= '0;
    else if (i_en & ~&o_count) o_count <= o_count + width_p'(1);
endmodule

// File: rtl/bsg_fifo_saf_commit_ctrl.sv
// bsg_fifo_saf_commit_ctrl: frames packets into a store-and-forward FIFO and issues one commit/drop per packet
module bsg_fifo_saf_commit_ctrl
  import bsg_fifo_saf_commit_pkg::*;
#(
  parameter int width_p       = 8,
  parameter int lg_size_p     = 4,
  parameter int max_beats_p   = 1 << lg_size_p,
  parameter int stall_limit_p = 16,
  parameter int cnt_width_p   = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     data_i,
  input  logic                   v_i,
  input  logic                   last_i,
  input  logic                   err_i,
  output logic                   ready_o,
  output logic [width_p-1:0]     fifo_data_o,
  output logic                   fifo_v_o,
  input  logic                   fifo_ready_i,
  output logic                   commit_v_o,
  output logic                   commit_drop_o,
  output logic                   busy_o,
  output logic [cnt_width_p-1:0] commit_cnt_o,
  output logic [cnt_width_p-1:0] drop_cnt_o
);
  localparam int bw_lp = $clog2(max_beats_p + 1);
  localparam int sw_lp = $clog2(stall_limit_p + 1);
  state_e r_state, w_next;
  logic [bw_lp-1:0] r_beat_cnt;
  logic [sw_lp-1:0] r_stall_cnt;
  logic r_err, r_abort_last;
  logic w_rx, w_over, w_accept, w_stall, w_stall_hit;
  assign w_rx = (r_state == S_IDLE) | (r_state == S_RECV);
  assign w_over = r_beat_cnt == bw_lp'(max_beats_p);
  assign w_accept = v_i & ready_o;
  assign w_stall = (r_state == S_RECV) & v_i & ~fifo_ready_i & ~w_over;
  assign w_stall_hit = w_stall & (r_stall_cnt == sw_lp'(stall_limit_p - 1));
  assign fifo_data_o = data_i;
  always_ff @(posedge clk_i)
    if (reset_i) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = last_i ? S_COMMIT : S_RECV;
      S_RECV:    if (v_i & w_over) w_next = S_ABORT;
                 else if (w_accept & last_i) w_next = S_COMMIT;
                 else if (w_stall_hit) w_next = S_ABORT;
      S_COMMIT:  w_next = S_IDLE;
      S_ABORT:   w_next = r_abort_last ? S_IDLE : S_DISCARD;
      S_DISCARD: if (w_accept & last_i) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end
  // the overlength beat is swallowed even when the FIFO is not ready
  always_comb begin
    ready_o = ~reset_i & (w_rx ? (fifo_ready_i | w_over) : (r_state == S_DISCARD));
    fifo_v_o = ~reset_i & w_rx & v_i & fifo_ready_i & ~w_over;
    commit_v_o = ~reset_i & ((r_state == S_COMMIT) | (r_state == S_ABORT));
    commit_drop_o = ~reset_i & ((r_state == S_ABORT) ? DISP_DROP : (r_state == S_COMMIT) ? r_err : DISP_COMMIT);
    busy_o = ~reset_i & (r_state != S_IDLE);
  end
  always_ff @(posedge clk_i)
    if (reset_i | ~w_rx) begin
      r_beat_cnt <= '0;
      r_stall_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_accept & ~w_over) begin
      r_beat_cnt <= r_beat_cnt + bw_lp'(1);
      r_stall_cnt <= '0;
      r_err <= r_err | err_i;
    end else if (w_stall) r_stall_cnt <= r_stall_cnt + sw_lp'(1);
  always_ff @(posedge clk_i)
    if (reset_i) r_abort_last <= 1'b0;
    else if ((r_state == S_RECV) & (w_next == S_ABORT)) r_abort_last <= v_i & w_over & last_i;
  bsg_fifo_saf_sat_counter #(.width_p(cnt_width_p)) u_commit_cnt (
    .i_clk(clk_i), .i_reset(reset_i), .i_en(commit_v_o & ~commit_drop_o), .o_count(commit_cnt_o)
  );
  bsg_fifo_saf_sat_counter #(.width_p(cnt_width_p)) u_drop_cnt (
    .i_clk(clk_i), .i_reset(reset_i), .i_en(commit_v_o & commit_drop_o), .o_count(drop_cnt_o)
  );
endmodule

// File: tb/tb_bsg_fifo_saf_commit_ctrl.sv
// tb_bsg_fifo_saf_commit_ctrl: directed vectors for the SAF commit controller (max 4 beats, stall limit 4, 4-bit counters)
module tb_bsg_fifo_saf_commit_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_i, v_i, last_i, err_i, fifo_ready_i;
  logic [7:0] data_i, fifo_data_o;
  logic ready_o, fifo_v_o, commit_v_o, commit_drop_o, busy_o;
  logic [3:0] commit_cnt_o, drop_cnt_o;
  int n_tests = 0;
  int n_fail = 0;
  bsg_fifo_saf_commit_ctrl #(
    .width_p(8), .lg_size_p(2), .max_beats_p(4), .stall_limit_p(4), .cnt_width_p(4)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i), .last_i(last_i), .err_i(err_i),
    .ready_o(ready_o), .fifo_data_o(fifo_data_o), .fifo_v_o(fifo_v_o), .fifo_ready_i(fifo_ready_i),
    .commit_v_o(commit_v_o), .commit_drop_o(commit_drop_o), .busy_o(busy_o),
    .commit_cnt_o(commit_cnt_o), .drop_cnt_o(drop_cnt_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic v, input logic l, input logic e, input logic fr);
    v_i = v;
    last_i = l;
    err_i = e;
    fifo_ready_i = fr;
    #1;
  endtask
  task automatic out(input string tag, input logic rdy, input logic fv, input logic cv, input logic cd, input logic bz);
    check({tag, "_ready"}, ready_o, rdy);
    check({tag, "_fifo_v"}, fifo_v_o, fv);
    check({tag, "_commit_v"}, commit_v_o, cv);
    check({tag, "_drop"}, commit_drop_o, cd);
    check({tag, "_busy"}, busy_o, bz);
  endtask
  task automatic cnts(input string tag, input logic [3:0] c, input logic [3:0] d);
    check({tag, "_commit_cnt"}, commit_cnt_o, c);
    check({tag, "_drop_cnt"}, drop_cnt_o, d);
  endtask
  initial begin
    reset_i = 1'b1;
    data_i = 8'h00;
    drv(0, 0, 0, 1);
    tick;
    tick;
    drv(0, 0, 0, 1);
    out("por", 0, 0, 0, 0, 0);
    cnts("por", 0, 0);
    reset_i = 1'b0;
    tick;
    data_i = 8'h3c;
    drv(1, 0, 0, 1);
    out("p3_b0", 1, 1, 0, 0, 0);
    check("p3_data", fifo_data_o, 8'h3c);
    tick;
    drv(1, 0, 0, 1);
    out("p3_b1", 1, 1, 0, 0, 1);
    tick;
    drv(1, 1, 0, 1);
    out("p3_b2", 1, 1, 0, 0, 1);
    tick;
    drv(0, 0, 0, 1);
    out("p3_cmt", 0, 0, 1, 0, 1);
    tick;
    drv(0, 0, 0, 1);
    out("p3_idle", 1, 0, 0, 0, 0);
    cnts("p3", 1, 0);
    tick;
    drv(1, 0, 1, 1);
    out("e2_b0", 1, 1, 0, 0, 0);
    tick;
    drv(1, 1, 0, 1);
    out("e2_b1", 1, 1, 0, 0, 1);
    tick;
    drv(0, 0, 0, 1);
    out("e2_cmt", 0, 0, 1, 1, 1);
    tick;
    drv(0, 0, 0, 1);
    cnts("e2", 1, 1);
    tick;
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, 0, 1);
      out("ov_b", 1, 1, 0, 0, i != 0);
      tick;
    end
    drv(1, 0, 0, 1);
    out("ov_b5", 1, 0, 0, 0, 1);
    tick;
    drv(1, 1, 0, 1);
    out("ov_abort", 0, 0, 1, 1, 1);
    tick;
    drv(1, 1, 0, 1);
    out("ov_disc", 1, 0, 0, 0, 1);
    tick;
    drv(1, 1, 0, 1);
    out("ov_next", 1, 1, 0, 0, 0);
    tick;
    drv(0, 0, 0, 1);
    out("ov_next_cmt", 0, 0, 1, 0, 1);
    tick;
    drv(0, 0, 0, 1);
    cnts("ov", 2, 2);
    tick;
    drv(1, 0, 0, 1);
    out("st_b1", 1, 1, 0, 0, 0);
    tick;
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, 0, 0);
      out("st_stall", 0, 0, 0, 0, 1);
      tick;
    end
    drv(1, 0, 0, 1);
    out("st_abort", 0, 0, 1, 1, 1);
    tick;
    drv(1, 0, 0, 1);
    out("st_disc2", 1, 0, 0, 0, 1);
    tick;
    drv(1, 1, 0, 1);
    out("st_disc3", 1, 0, 0, 0, 1);
    tick;
    drv(0, 0, 0, 1);
    out("st_idle", 1, 0, 0, 0, 0);
    cnts("st", 2, 3);
    tick;
    for (int i = 0; i < 6; i++) begin
      drv(1, 1, 0, 1);
      out("b2b", i % 2 == 0, i % 2 == 0, i % 2 == 1, 0, i % 2 == 1);
      tick;
    end
    drv(0, 0, 0, 1);
    cnts("b2b", 5, 3);
    tick;
    drv(1, 0, 0, 1);
    tick;
    drv(1, 0, 0, 1);
    tick;
    reset_i = 1'b1;
    drv(0, 0, 0, 1);
    tick;
    drv(0, 0, 0, 1);
    out("mid_rst", 0, 0, 0, 0, 0);
    cnts("mid_rst", 0, 0);
    reset_i = 1'b0;
    tick;
    drv(0, 0, 0, 1);
    out("post_rst", 1, 0, 0, 0, 0);
    tick;
    drv(1, 0, 0, 1);
    out("post_b0", 1, 1, 0, 0, 0);
    tick;
    drv(1, 1, 0, 1);
    tick;
    drv(0, 0, 0, 1);
    out("post_cmt", 0, 0, 1, 0, 1);
    tick;
    drv(0, 0, 0, 1);
    cnts("post", 1, 0);
    for (int i = 0; i < 14; i++) begin
      drv(1, 1, 0, 1);
      tick;
      drv(0, 0, 0, 1);
      tick;
    end
    drv(0, 0, 0, 1);
    cnts("sat_full", 15, 0);
    drv(1, 1, 0, 1);
    tick;
    drv(0, 0, 0, 1);
    out("sat_cmt", 0, 0, 1, 0, 1);
    tick;
    drv(0, 0, 0, 1);
    cnts("sat_hold", 15, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
